// File: rtl/demux1x3_buf.sv
// Registered 1:3 distributor: routes in_data to slot A/B/C by in_sel, 1-cycle latency, one word/cycle per slot.
// A stalled slot only blocks words addressed to it; in_ready is combinational from the selected slot's ready.

module demux1x3_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             can_load
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (valid_q && out_ready) begin
      // data is left as-is after a drain; only valid falls
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  // a full slot can still take a word in the same cycle it is drained
  assign can_load  = !valid_q || out_ready;

endmodule

module demux1x3_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_a_data,
  output logic             out_a_valid,
  input  logic             out_a_ready,
  output logic [WIDTH-1:0] out_b_data,
  output logic             out_b_valid,
  input  logic             out_b_ready,
  output logic [WIDTH-1:0] out_c_data,
  output logic             out_c_valid,
  input  logic             out_c_ready,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [1:0] SEL_ILLEGAL = 2'd3;

  logic             accept;
  logic             illegal_acc;
  logic [2:0]       slot_load;
  logic [2:0]       slot_can_load;
  logic [2:0]       slot_valid;
  logic [2:0]       slot_ready;
  logic [WIDTH-1:0] slot_data [3];

  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  assign slot_ready = {out_c_ready, out_b_ready, out_a_ready};

  // ready never looks at in_valid, so producers may wait on it before asserting valid
  always_comb begin
    in_ready = 1'b1;
    if (in_sel != SEL_ILLEGAL) begin
      in_ready = slot_can_load[in_sel];
    end
  end

  assign accept      = in_valid && in_ready;
  assign illegal_acc = accept && (in_sel == SEL_ILLEGAL);

  for (genvar i = 0; i < 3; i++) begin : g_slot
    assign slot_load[i] = accept && (in_sel == 2'(i));

    demux1x3_slot #(
      .WIDTH(WIDTH)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (slot_load[i]),
      .load_data(in_data),
      .out_ready(slot_ready[i]),
      .out_valid(slot_valid[i]),
      .out_data (slot_data[i]),
      .can_load (slot_can_load[i])
    );

    a_hold_when_stalled: assert property (
      @(posedge clk) disable iff (!rst_n)
      slot_valid[i] && !slot_ready[i] |=> slot_valid[i] && $stable(slot_data[i])
    );
  end

  always_comb begin
    err_pulse_d = illegal_acc;
    err_cnt_d   = err_cnt_q;
    if (illegal_acc && (err_cnt_q != {CNT_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_pulse_q <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= err_pulse_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  a_err_follows_illegal: assert property (
    @(posedge clk) disable iff (!rst_n)
    illegal_acc |=> err_pulse
  );

  assign err_pulse   = err_pulse_q;
  assign err_cnt     = err_cnt_q;

  assign out_a_data  = slot_data[0];
  assign out_a_valid = slot_valid[0];
  assign out_b_data  = slot_data[1];
  assign out_b_valid = slot_valid[1];
  assign out_c_data  = slot_data[2];
  assign out_c_valid = slot_valid[2];

endmodule
